// File: rtl/stage_skid_reg_pkg.sv
// Shared definitions for the pipeline stage registers: reset level, exception
// encoding, default lane geometry and the EX/MEM payload layout.
package stage_skid_reg_pkg;

    localparam logic RstEnable = 1'b0;

    localparam int EXC_NONE  = 0;
    localparam int LANES_DEF = 2;
    localparam int EXC_W_DEF = 2;

    // Per-lane EX->MEM payload. Both stages pack/unpack through this struct so
    // the bit positions can never drift apart.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] wdata;
        logic [31:0] reg2;
        logic [17:0] mem_addr;
        logic [7:0]  aluop;
        logic [4:0]  wd;
        logic        wreg;
    } ex_mem_payload_t;

    localparam int DATA_W_DEF = $bits(ex_mem_payload_t);

    function automatic logic [DATA_W_DEF-1:0] pack_payload(input ex_mem_payload_t p);
        return p;
    endfunction

    function automatic ex_mem_payload_t unpack_payload(input logic [DATA_W_DEF-1:0] b);
        return ex_mem_payload_t'(b);
    endfunction

endpackage

// File: rtl/stage_skid_reg_entry.sv
// One bundle-wide entry register (valid bits, payload, exception codes) with
// clear > load > hold priority.
module stage_entry
    import stage_skid_reg_pkg::*;
#(
    parameter int LANES  = LANES_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int EXC_W  = EXC_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    clear,
    input  logic [LANES-1:0]        d_valid,
    input  logic [LANES*DATA_W-1:0] d_data,
    input  logic [LANES*EXC_W-1:0]  d_excp,
    output logic [LANES-1:0]        q_valid,
    output logic [LANES*DATA_W-1:0] q_data,
    output logic [LANES*EXC_W-1:0]  q_excp,
    output logic                    occupied
);

    always_ff @(posedge clk) begin
        if (rst == RstEnable || clear) begin
            q_valid <= '0;
            q_data  <= '0;
            q_excp  <= '0;
        end else if (load) begin
            q_valid <= d_valid;
            q_data  <= d_data;
            q_excp  <= d_excp;
        end
    end

    assign occupied = |q_valid;

endmodule

// File: rtl/stage_skid_reg.sv
// Multi-lane pipeline stage register with registered ready, one-entry skid
// buffer, flush and in-order exception squashing of younger lanes.
module stage_skid_reg
    import stage_skid_reg_pkg::*;
#(
    parameter int LANES  = LANES_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int EXC_W  = EXC_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [LANES-1:0]        in_valid,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic [LANES*EXC_W-1:0]  in_excp,
    output logic                    in_ready,
    output logic [LANES-1:0]        out_valid,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [LANES*EXC_W-1:0]  out_excp,
    output logic                    out_excp_any,
    input  logic                    out_ready
);

    // Lanes younger than the oldest valid excepting lane are dropped; the
    // excepting lane itself survives so MEM can raise the trap.
    function automatic logic [LANES-1:0] squash_keep(input logic [LANES-1:0]       v,
                                                      input logic [LANES*EXC_W-1:0] e);
        logic [LANES-1:0] keep;
        logic             kill;
        keep = '1;
        kill = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (kill) begin
                keep[i] = 1'b0;
            end else if (v[i] && e[i*EXC_W +: EXC_W] != EXC_W'(EXC_NONE)) begin
                kill = 1'b1;
            end
        end
        return keep;
    endfunction

    logic [LANES-1:0]        keep;
    logic [LANES-1:0]        sq_valid;
    logic [LANES*DATA_W-1:0] sq_data;
    logic [LANES*EXC_W-1:0]  sq_excp;

    assign keep     = squash_keep(in_valid, in_excp);
    assign sq_valid = in_valid & keep;

    for (genvar g = 0; g < LANES; g++) begin : g_gate
        assign sq_data[g*DATA_W +: DATA_W] = keep[g] ? in_data[g*DATA_W +: DATA_W] : '0;
        assign sq_excp[g*EXC_W +: EXC_W]   = keep[g] ? in_excp[g*EXC_W +: EXC_W]   : '0;
    end

    logic [LANES-1:0]        skid_valid;
    logic [LANES*DATA_W-1:0] skid_data;
    logic [LANES*EXC_W-1:0]  skid_excp;
    logic                    main_occ;
    logic                    skid_occ;

    logic                    accept;
    logic                    consume;
    logic                    main_free;
    logic                    main_load;
    logic                    main_clear;
    logic                    skid_load;
    logic                    skid_clear;
    logic                    skid_occ_next;

    logic [LANES-1:0]        main_d_valid;
    logic [LANES*DATA_W-1:0] main_d_data;
    logic [LANES*EXC_W-1:0]  main_d_excp;

    assign accept    = in_ready && (|in_valid) && !flush;
    assign consume   = main_occ && out_ready && !flush;
    assign main_free = !main_occ || consume;

    always_comb begin
        main_load     = 1'b0;
        main_clear    = 1'b0;
        skid_load     = 1'b0;
        skid_clear    = 1'b0;
        skid_occ_next = skid_occ;
        main_d_valid  = sq_valid;
        main_d_data   = sq_data;
        main_d_excp   = sq_excp;

        if (flush) begin
            main_clear    = 1'b1;
            skid_clear    = 1'b1;
            skid_occ_next = 1'b0;
        end else if (main_free) begin
            if (skid_occ) begin
                main_load     = 1'b1;
                main_d_valid  = skid_valid;
                main_d_data   = skid_data;
                main_d_excp   = skid_excp;
                skid_clear    = 1'b1;
                skid_occ_next = 1'b0;
            end else if (accept) begin
                main_load = 1'b1;
            end else begin
                main_clear = 1'b1;
            end
        end else if (accept) begin
            // in_ready guarantees the skid is empty here.
            skid_load     = 1'b1;
            skid_occ_next = 1'b1;
        end
    end

    stage_entry #(
        .LANES  (LANES),
        .DATA_W (DATA_W),
        .EXC_W  (EXC_W)
    ) u_main (
        .clk      (clk),
        .rst      (rst),
        .load     (main_load),
        .clear    (main_clear),
        .d_valid  (main_d_valid),
        .d_data   (main_d_data),
        .d_excp   (main_d_excp),
        .q_valid  (out_valid),
        .q_data   (out_data),
        .q_excp   (out_excp),
        .occupied (main_occ)
    );

    stage_entry #(
        .LANES  (LANES),
        .DATA_W (DATA_W),
        .EXC_W  (EXC_W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .load     (skid_load),
        .clear    (skid_clear),
        .d_valid  (sq_valid),
        .d_data   (sq_data),
        .d_excp   (sq_excp),
        .q_valid  (skid_valid),
        .q_data   (skid_data),
        .q_excp   (skid_excp),
        .occupied (skid_occ)
    );

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            in_ready <= 1'b1;
        end else begin
            in_ready <= !skid_occ_next;
        end
    end

    always_comb begin
        out_excp_any = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (out_valid[i] && out_excp[i*EXC_W +: EXC_W] != EXC_W'(EXC_NONE)) begin
                out_excp_any = 1'b1;
            end
        end
    end

endmodule

// File: doc/stage_skid_reg.md
# stage_skid_reg

Parametrised, multi-lane pipeline stage register with valid/ready handshake, a one-entry skid buffer, flush, and in-order exception squashing. It replaces fixed-width, single-lane stage latches between EX and MEM (and any other stage pair) in the dual-issue pipeline. Upstream stalls are absorbed without a combinational ready path. Exceptions raised in an older lane invalidate younger lanes in the same bundle at capture time.

## Interface
Parameters:
- LANES, 2, issue lanes per bundle; lane 0 is oldest.
- DATA_W, 128, payload bits per lane (wd, wreg, wdata, pc, aluop, mem_addr, reg2, … packed by the instantiating stage).
- EXC_W, 2, exception-code bits per lane; code 0 means no exception.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-low reset.
- flush  in  1  discard all held and incoming bundles this cycle.
- in_valid  in  LANES  per-lane valid of the incoming bundle.
- in_data  in  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W].
- in_excp  in  LANES*EXC_W  per-lane exception code.
- in_ready  out  1  stage can accept a bundle; registered.
- out_valid  out  LANES  per-lane valid of the head bundle.
- out_data  out  LANES*DATA_W  head bundle payload.
- out_excp  out  LANES*EXC_W  head bundle exception codes.
- out_excp_any  out  1  some valid head lane has a nonzero code.
- out_ready  in  1  downstream consumes the head bundle.

## Operation
- Storage: main entry (drives outputs) and skid entry. Each entry holds LANES valid bits, data and exception codes.
- An entry is occupied iff any of its lane valids is 1.
- Accept: in_ready && |in_valid && !flush. A bundle with all lanes invalid is never captured.
- Consume: main occupied && out_ready && !flush.
- Squash on capture: let k be the lowest lane with in_valid[k] && in_excp[k]!=0.
  - Lanes j>k are stored with valid=0, data=0, excp=0.
  - Lane k keeps its valid bit and its code.
- Main-entry update, in priority order:
  - rst low: clear both entries.
  - flush: clear both entries.
  - Main empty, or consumed: load the skid entry if it is occupied, else the accepted bundle, else clear.
  - Otherwise main holds.
- Skid-entry update:
  - Skid is written only when a bundle is accepted while main is occupied and not consumed.
  - Skid is cleared when its contents move to main.
  - Skid is never written while it is occupied, because in_ready=0 then.
- A simultaneous accept and consume with the skid occupied is impossible (in_ready=0).
- With the skid empty, the accepted bundle goes straight to main.
- in_ready next value = !(skid occupied next).
- out_excp_any is combinational from the main entry only.

## Timing
- Reset values (after a clk edge with rst=0):
  - out_valid=0, out_data=0, out_excp=0, out_excp_any=0.
  - skid cleared; in_ready=1.
- Latency: an accepted bundle appears on out_* the next cycle when the stage was empty or is being drained.
- Throughput: one bundle per cycle while out_ready=1.
- in_ready:
  - Deasserts the cycle after the skid fills.
  - Reasserts the cycle after the skid drains to main.
  - It never depends combinationally on out_ready.
- Flush:
  - Effective the same edge: both entries are cleared and any handshake in that cycle is void on both sides.
  - in_ready=1 the next cycle.
  - Flush and rst low together: reset wins; the result is identical.
- Reset mid-stall: all contents are lost; no bundle re-emerges.
- out_* is stable while out_valid!=0 and out_ready=0.

## Structure
- Shared defines: RstEnable=1'b0, the no-exception code (0), and the default LANES/EXC_W constants. The stage-payload bit layouts also live there, so EX and MEM pack and unpack identically.
- Sub-module stage_entry: one entry register with load, clear and hold controls. It is instantiated twice (main, skid).
- The squash mask is a pure function computed once on the input side.

## Test plan
Configuration: LANES=2, DATA_W=32, EXC_W=2.
- **Reset:** rst=0 for 2 cycles, then rst=1 → out_valid=2'b00, in_ready=1, out_data=0.
- **Pass-through:** in_valid=2'b11, data {0xB,0xA}, excp 0, out_ready=1 each cycle for 4 bundles → each bundle appears one cycle later, in order; in_ready stays 1.
- **Stall and skid:**
  - Hold out_ready=0 while pushing bundles X then Y → out shows X; Y goes to the skid; in_ready=0 from the next cycle; a third offered bundle Z is not accepted.
  - Raise out_ready → X, then Y, then Z (now accepted) delivered, with no loss or duplication.
- **Exception squash:** in_valid=2'b11, in_excp lane0=2'b01, lane1=0 → out_valid=2'b01, lane1 data=0, out_excp_any=1. Separately, lane1 excp=2'b10 with lane0 clean → out_valid=2'b11.
- **Flush while full:** main and skid occupied and out_ready=0; assert flush together with in_valid=2'b11 → next cycle out_valid=0, in_ready=1, the flushed input is not captured.
- **Reset mid-stall:** both entries full, then rst=0 for 1 cycle → out_valid=0, in_ready=1; after rst=1 no old bundle reappears.
